// File: rtl/pe27_feeder_if.sv
// Bundle of the operand stream, MAC, result and status signals of the feeder.
// master: the feeder side (drives s_ready, MAC operands/start, result, status).
// slave: the environment side (operand source, MAC engine, result consumer).
interface pe27_feeder_if;
    logic         w_load;
    logic         s_valid;
    logic         s_ready;
    logic [7:0]   s_data;
    logic         mac_start;
    logic [215:0] mac_weights_flat;
    logic [215:0] mac_inputs_flat;
    logic         mac_busy;
    logic         mac_done;
    logic [23:0]  mac_out;
    logic         res_valid;
    logic         res_ready;
    logic [23:0]  res_data;
    logic         w_loaded;
    logic         busy;
    logic         err;

    modport master (
        input  w_load, s_valid, s_data, mac_busy, mac_done, mac_out, res_ready,
        output s_ready, mac_start, mac_weights_flat, mac_inputs_flat,
               res_valid, res_data, w_loaded, busy, err
    );

    modport slave (
        output w_load, s_valid, s_data, mac_busy, mac_done, mac_out, res_ready,
        input  s_ready, mac_start, mac_weights_flat, mac_inputs_flat,
               res_valid, res_data, w_loaded, busy, err
    );
endinterface

// File: rtl/pe27_feeder.sv
// Buffers 27 weight and 27 activation bytes from a byte stream and drives a 27-tap MAC.
// Latency: last activation handshake -> mac_start 1 cycle; mac_done -> res_valid 1 cycle.
// Backpressure: s_ready only while loading (from state); result held in OUT until res_ready.
module pe27_feeder #(
    parameter int WAIT_MAX = 512
) (
    input  logic          clk,
    input  logic          rst_n,
    pe27_feeder_if.master bus
);

    localparam logic [4:0] LAST_IDX = 5'd26;
    localparam int         WCW      = $clog2(WAIT_MAX + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_X = 3'd2,
        START  = 3'd3,
        WAIT   = 3'd4,
        OUT    = 3'd5
    } state_t;

    state_t         state;
    logic [4:0]     cnt;
    logic [WCW-1:0] wcnt;
    logic           mac_start_q;
    logic           res_valid_q;
    logic [23:0]    res_data_q;
    logic           w_loaded_q;
    logic           err_q;
    logic [215:0]   wbuf;
    logic [215:0]   xbuf;
    logic [7:0]     byte_base;

    // Byte lane of the current load slot; cnt never exceeds 26 so the lane stays in range.
    assign byte_base = {cnt, 3'b000};

    // Control FSM; buffers, counters and all registered outputs live here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            wcnt        <= '0;
            mac_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            w_loaded_q  <= 1'b0;
            err_q       <= 1'b0;
            wbuf        <= '0;
            xbuf        <= '0;
        end else begin
            mac_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    // A reload request wins over starting another window.
                    if (bus.w_load) begin
                        state      <= LOAD_W;
                        w_loaded_q <= 1'b0;
                        cnt        <= '0;
                    end else if (w_loaded_q) begin
                        state <= LOAD_X;
                        cnt   <= '0;
                    end
                end
                LOAD_W: begin
                    if (bus.s_valid) begin
                        wbuf[byte_base +: 8] <= bus.s_data;
                        if (cnt == LAST_IDX) begin
                            cnt        <= '0;
                            w_loaded_q <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                LOAD_X: begin
                    if (bus.s_valid) begin
                        xbuf[byte_base +: 8] <= bus.s_data;
                        if (cnt == LAST_IDX) begin
                            cnt         <= '0;
                            mac_start_q <= 1'b1;
                            state       <= START;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                START: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the timeout cycle still counts as a result.
                    if (bus.mac_done) begin
                        res_data_q  <= bus.mac_out;
                        res_valid_q <= 1'b1;
                        state       <= OUT;
                    end else if (wcnt == WAIT_LAST) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wcnt <= wcnt + WCW'(1);
                    end
                end
                OUT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Ready depends on state only, so the source may wait on it without a loop through s_valid.
    assign bus.s_ready          = (state == LOAD_W) || (state == LOAD_X);
    assign bus.busy             = (state != IDLE);
    assign bus.mac_start        = mac_start_q;
    assign bus.mac_weights_flat = wbuf;
    assign bus.mac_inputs_flat  = xbuf;
    assign bus.res_valid        = res_valid_q;
    assign bus.res_data         = res_data_q;
    assign bus.w_loaded         = w_loaded_q;
    assign bus.err              = err_q;

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt <= LAST_IDX);
    a_start_in_start: assert property (@(posedge clk) disable iff (!rst_n)
        mac_start_q |-> (state == START));
    a_res_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (state == OUT && !bus.res_ready) |=> (res_valid_q && $stable(res_data_q)));
    a_err_sticky: assert property (@(posedge clk) disable iff (!rst_n) err_q |=> err_q);

endmodule

// File: tb/tb_pe27_feeder.sv
// Scoreboard bench for pe27_feeder: byte source, behavioural MAC and result consumer.
// Expected dot products are pushed when activations are driven and popped at each result.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pe27_feeder;

    localparam int WAIT_MAX = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pe27_feeder_if bus();

    pe27_feeder #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int start_cnt = 0;
    int rv_cnt = 0;
    int done_cyc = 0;
    bit mac_hang = 1'b0;
    logic [23:0] exp_q[$];
    logic [7:0] wts [27];
    logic [7:0] acts [27];

    // Event counters observed at the active edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.s_valid && bus.s_ready) acc_cnt <= acc_cnt + 1;
        if (bus.mac_start) start_cnt <= start_cnt + 1;
        if (bus.res_valid) rv_cnt <= rv_cnt + 1;
    end

    // Behavioural MAC: three cycles after a start, pulse done with the dot product.
    initial begin
        logic [23:0] sum;
        bus.mac_done = 1'b0;
        bus.mac_out  = '0;
        bus.mac_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mac_start && !mac_hang) begin
                sum = '0;
                for (int i = 0; i < 27; i++)
                    sum += 24'(bus.mac_weights_flat[i*8 +: 8]) * 24'(bus.mac_inputs_flat[i*8 +: 8]);
                bus.mac_busy = 1'b1;
                repeat (3) @(negedge clk);
                bus.mac_done = 1'b1;
                bus.mac_out  = sum;
                done_cyc     = cyc;
                @(negedge clk);
                bus.mac_done = 1'b0;
                bus.mac_busy = 1'b0;
            end
        end
    end

    function automatic logic [23:0] dot();
        logic [23:0] s = '0;
        for (int i = 0; i < 27; i++) s += 24'(wts[i]) * 24'(acts[i]);
        return s;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.w_load = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.res_ready = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic pulse_wload();
        bus.w_load = 1'b1;
        tick(1);
        bus.w_load = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int max_gap);
        int t = 0;
        bus.s_valid = 1'b0;
        if (max_gap > 0) tick(int'($urandom_range(0, max_gap)));
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (bus.s_ready !== 1'b1 && t < 50) begin tick(1); t++; end
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL send_byte: s_ready=%b after 50 cycles, required 1", bus.s_ready);
        end
        tick(1);
        bus.s_valid = 1'b0;
    endtask

    task automatic send_weights(input int gap);
        for (int i = 0; i < 27; i++) send_byte(wts[i], gap);
    endtask

    task automatic send_acts(input int gap, input bit expect_res, input int wl_at);
        if (expect_res) exp_q.push_back(dot());
        for (int i = 0; i < 27; i++) begin
            if (i == wl_at) begin
                pulse_wload();
                checks++;
                if (bus.w_loaded !== 1'b1 || bus.s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL wload_ignored: w_loaded=%b s_ready=%b, required 1 1", bus.w_loaded, bus.s_ready);
                end
            end
            send_byte(acts[i], gap);
        end
        checks++;
        if (bus.mac_start !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: mac_start=%b one cycle after last byte, required 1", bus.mac_start);
        end
        tick(1);
        checks++;
        if (bus.mac_start !== 1'b0) begin
            errors++;
            $display("FAIL start_width: mac_start=%b in second cycle, required 0", bus.mac_start);
        end
    endtask

    task automatic collect(input int stall, input bit reload);
        int t = 0;
        int bad = 0;
        logic [23:0] held;
        logic [23:0] e;
        while (bus.res_valid !== 1'b1 && t < 2000) begin tick(1); t++; end
        checks++;
        if (bus.res_valid !== 1'b1) begin
            errors++;
            $display("FAIL res_timeout: res_valid=%b after 2000 cycles, required 1", bus.res_valid);
            return;
        end
        checks++;
        if (cyc !== done_cyc + 1) begin
            errors++;
            $display("FAIL done_to_valid: %0d cycles, required 1", cyc - done_cyc);
        end
        held = bus.res_data;
        bus.res_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            tick(1);
            if (bus.res_valid !== 1'b1 || bus.res_data !== held) bad++;
        end
        if (stall > 0) begin
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL res_stall: %0d unstable cycles (res_valid=%b res_data=%0d), required 0 (1 %0d)",
                         bad, bus.res_valid, bus.res_data, held);
            end
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: unexpected result %0d, required none", bus.res_data);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.res_data !== e) begin
                errors++;
                $display("FAIL res_data: got %0d, required %0d", bus.res_data, e);
            end
        end
        bus.res_ready = 1'b1;
        tick(1);
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL res_release: res_valid=%b busy=%b, required 0 0", bus.res_valid, bus.busy);
        end
        if (reload) pulse_wload();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        checks++;
        if ({bus.s_ready, bus.mac_start, bus.res_valid, bus.w_loaded, bus.busy, bus.err} !== 6'b0 ||
            bus.res_data !== 24'd0 || bus.mac_weights_flat !== '0 || bus.mac_inputs_flat !== '0) begin
            errors++;
            $display("FAIL reset_state: s_ready=%b mac_start=%b res_valid=%b w_loaded=%b busy=%b err=%b res_data=%0d, required all 0",
                     bus.s_ready, bus.mac_start, bus.res_valid, bus.w_loaded, bus.busy, bus.err, bus.res_data);
        end
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b s_ready=%b, required 0 0", bus.busy, bus.s_ready);
        end
    endtask

    task automatic test_ones();
        int s0;
        apply_reset();
        s0 = start_cnt;
        for (int i = 0; i < 27; i++) begin wts[i] = 8'd1; acts[i] = 8'd1; end
        pulse_wload();
        send_weights(0);
        checks++;
        if (bus.w_loaded !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL weights_done: w_loaded=%b busy=%b, required 1 0", bus.w_loaded, bus.busy);
        end
        send_acts(0, 1'b1, -1);
        collect(10, 1'b0);
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL start_count: %0d pulses, required 1", start_cnt - s0);
        end
    endtask

    task automatic test_partial();
        logic [71:0] low_w;
        logic [71:0] low_x;
        apply_reset();
        for (int i = 0; i < 27; i++) begin
            wts[i]  = (i < 9) ? 8'd2 : 8'd0;
            acts[i] = (i < 9) ? 8'd3 : 8'd0;
        end
        low_w = {9{8'h02}};
        low_x = {9{8'h03}};
        pulse_wload();
        send_weights(0);
        checks++;
        if (bus.mac_weights_flat[71:0] !== low_w || bus.mac_weights_flat[215:72] !== '0) begin
            errors++;
            $display("FAIL weights_flat: got %h, required low 72 bits %h, rest 0", bus.mac_weights_flat, low_w);
        end
        send_acts(0, 1'b1, -1);
        checks++;
        if (bus.mac_inputs_flat[71:0] !== low_x || bus.mac_inputs_flat[215:72] !== '0) begin
            errors++;
            $display("FAIL inputs_flat: got %h, required low 72 bits %h, rest 0", bus.mac_inputs_flat, low_x);
        end
        collect(0, 1'b0);
    endtask

    task automatic test_reuse();
        apply_reset();
        for (int i = 0; i < 27; i++) begin wts[i] = 8'd2; acts[i] = 8'd1; end
        pulse_wload();
        send_weights(0);
        send_acts(0, 1'b1, -1);
        collect(0, 1'b0);
        for (int i = 0; i < 27; i++) acts[i] = 8'd2;
        send_acts(0, 1'b1, 5);
        checks++;
        if (bus.w_loaded !== 1'b1) begin
            errors++;
            $display("FAIL reuse_w_loaded: w_loaded=%b, required 1", bus.w_loaded);
        end
        collect(0, 1'b1);
        for (int i = 0; i < 27; i++) begin wts[i] = 8'd3; acts[i] = 8'd1; end
        send_weights(0);
        send_acts(0, 1'b1, -1);
        collect(0, 1'b0);
    endtask

    task automatic test_back_to_back_gaps();
        int a0;
        apply_reset();
        for (int i = 0; i < 27; i++) wts[i] = 8'($urandom);
        pulse_wload();
        a0 = acc_cnt;
        send_weights(3);
        checks++;
        if (acc_cnt - a0 !== 27) begin
            errors++;
            $display("FAIL weight_accepts: %0d bytes, required 27", acc_cnt - a0);
        end
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 27; i++) acts[i] = 8'($urandom);
            a0 = acc_cnt;
            send_acts(3, 1'b1, -1);
            checks++;
            if (acc_cnt - a0 !== 27) begin
                errors++;
                $display("FAIL act_accepts: window %0d took %0d bytes, required 27", w, acc_cnt - a0);
            end
            collect(10, 1'b0);
        end
    endtask

    task automatic test_timeout();
        int t = 0;
        int r0;
        apply_reset();
        mac_hang = 1'b1;
        for (int i = 0; i < 27; i++) begin wts[i] = 8'd1; acts[i] = 8'd1; end
        pulse_wload();
        send_weights(0);
        send_acts(0, 1'b0, -1);
        r0 = rv_cnt;
        while (bus.err !== 1'b1 && t < WAIT_MAX + 20) begin tick(1); t++; end
        checks++;
        if (t !== WAIT_MAX) begin
            errors++;
            $display("FAIL timeout_cycles: err after %0d cycles in WAIT, required %0d", t, WAIT_MAX);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: busy=%b res_valid=%b, required 0 0", bus.busy, bus.res_valid);
        end
        tick(3);
        checks++;
        if (rv_cnt !== r0 || bus.err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_no_result: res_valid cycles=%0d err=%b, required 0 1", rv_cnt - r0, bus.err);
        end
        mac_hang = 1'b0;
        for (int i = 0; i < 27; i++) acts[i] = 8'd2;
        send_acts(0, 1'b1, -1);
        collect(0, 1'b0);
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, required 1", bus.err);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        int a0;
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 27; i++) begin wts[i] = 8'd5; acts[i] = 8'd4; end
        pulse_wload();
        for (int i = 0; i < 13; i++) send_byte(wts[i], 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.s_ready, bus.mac_start, bus.res_valid, bus.w_loaded, bus.busy, bus.err} !== 6'b0 ||
            bus.res_data !== 24'd0 || bus.mac_weights_flat !== '0 || bus.mac_inputs_flat !== '0) begin
            errors++;
            $display("FAIL mid_reset: s_ready=%b busy=%b w_loaded=%b weights=%h, required all 0",
                     bus.s_ready, bus.busy, bus.w_loaded, bus.mac_weights_flat);
        end
        tick(2);
        rst_n = 1'b1;
        s0 = start_cnt;
        a0 = acc_cnt;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'd9;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            if (bus.s_ready !== 1'b0 || bus.w_loaded !== 1'b0) bad++;
        end
        bus.s_valid = 1'b0;
        checks++;
        if (bad != 0 || start_cnt !== s0 || acc_cnt !== a0) begin
            errors++;
            $display("FAIL post_reset_idle: bad=%0d starts=%0d accepts=%0d, required 0 0 0",
                     bad, start_cnt - s0, acc_cnt - a0);
        end
        pulse_wload();
        send_weights(0);
        send_acts(0, 1'b1, -1);
        collect(0, 1'b0);
    endtask

    initial begin
        bus.w_load = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.res_ready = 1'b0;
        test_reset();
        test_ones();
        test_partial();
        test_reuse();
        test_back_to_back_gaps();
        test_timeout();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
